// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter that shares one APB requester among several local clients.
// Command fields are frozen at grant; completion is taken from the requester's Busy falling edge.
module apb_requester_arbiter #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int Slaves        = 4,
    parameter int Masters       = 3,
    parameter int TimeoutCycles = 256,
    localparam int StrbWidth    = DataWidth / 8,
    localparam int DecoSlaves   = (Slaves > 1) ? $clog2(Slaves) : 1,
    localparam int IdxW         = $clog2(Masters),
    localparam int CntW         = $clog2(TimeoutCycles + 1)
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [Masters-1:0]            Req,
    input  logic [Masters-1:0]            ReqWrite,
    input  logic [Masters*AddrWidth-1:0]  ReqAddr,
    input  logic [Masters*DecoSlaves-1:0] ReqSel,
    input  logic [Masters*DataWidth-1:0]  ReqData,
    input  logic [Masters*StrbWidth-1:0]  ReqStrb,
    output logic [Masters-1:0]            Grant,
    output logic [Masters-1:0]            Done,
    output logic [DataWidth-1:0]          RespData,
    output logic                          TimeoutErr,
    output logic                          Start,
    output logic                          RD,
    output logic                          WR,
    output logic [AddrWidth-1:0]          Addr,
    output logic [DecoSlaves-1:0]         Sel,
    output logic [DataWidth-1:0]          SendData,
    output logic [StrbWidth-1:0]          Strb,
    input  logic                          Busy,
    input  logic [DataWidth-1:0]          DataReceived
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IdxW-1:0]         r_ptr;
    logic                    r_write;
    logic [AddrWidth-1:0]    r_addr;
    logic [DecoSlaves-1:0]   r_sel;
    logic [DataWidth-1:0]    r_wdata;
    logic [StrbWidth-1:0]    r_strb;
    logic [Masters-1:0]      r_grant;
    logic [Masters-1:0]      r_done;
    logic [DataWidth-1:0]    r_resp;
    logic [CntW-1:0]         r_cnt;
    logic                    r_terr;
    logic                    w_any;
    logic                    w_hit;
    logic [IdxW-1:0]         w_win;
    logic [IdxW-1:0]         w_cand;
    logic [Masters-1:0]      w_onehot;

    // Round-robin search: first requester strictly after the last winner, wrapping.
    always_comb begin
        w_any    = 1'b0;
        w_hit    = 1'b0;
        w_win    = {IdxW{1'b0}};
        w_cand   = {IdxW{1'b0}};
        w_onehot = {Masters{1'b0}};
        for (int i = 1; i <= Masters; i++) begin
            w_cand = IdxW'((int'(r_ptr) + i) % Masters);
            w_hit  = Req[w_cand] & ~w_any;
            w_win  = w_hit ? w_cand : w_win;
            w_any  = w_any | w_hit;
        end
        w_onehot[w_win] = 1'b1;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; completion is the first XFER cycle that sees Busy low.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_XFER;
            S_XFER:  w_next = Busy ? S_XFER : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command strobes are a decode of the registered state.
    always_comb begin
        Start = 1'b0;
        RD    = 1'b0;
        WR    = 1'b0;
        case (r_state)
            S_ISSUE: begin
                Start = 1'b1;
                WR    = r_write;
                RD    = ~r_write;
            end
            default: begin
                Start = 1'b0;
            end
        endcase
    end

    // Grant-time field capture, timeout tracking and completion reporting.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ptr   <= IdxW'(Masters - 1);
            r_write <= 1'b0;
            r_addr  <= {AddrWidth{1'b0}};
            r_sel   <= {DecoSlaves{1'b0}};
            r_wdata <= {DataWidth{1'b0}};
            r_strb  <= {StrbWidth{1'b0}};
            r_grant <= {Masters{1'b0}};
            r_done  <= {Masters{1'b0}};
            r_resp  <= {DataWidth{1'b0}};
            r_cnt   <= {CntW{1'b0}};
            r_terr  <= 1'b0;
        end else begin
            r_done <= {Masters{1'b0}};
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_win;
                        r_grant <= w_onehot;
                        r_write <= ReqWrite[w_win];
                        r_addr  <= ReqAddr[w_win*AddrWidth +: AddrWidth];
                        r_sel   <= ReqSel[w_win*DecoSlaves +: DecoSlaves];
                        r_wdata <= ReqData[w_win*DataWidth +: DataWidth];
                        r_strb  <= ReqStrb[w_win*StrbWidth +: StrbWidth];
                    end
                end
                S_XFER: begin
                    if (Busy) begin
                        // Counter saturates; the flag is raised, the transfer keeps going.
                        if (r_cnt != CntW'(TimeoutCycles)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt == CntW'(TimeoutCycles - 1)) begin
                            r_terr <= 1'b1;
                        end
                    end else begin
                        r_done  <= r_grant;
                        r_grant <= {Masters{1'b0}};
                        r_cnt   <= {CntW{1'b0}};
                        if (!r_write) begin
                            r_resp <= DataReceived;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign Grant      = r_grant;
    assign Done       = r_done;
    assign RespData   = r_resp;
    assign TimeoutErr = r_terr;
    assign Addr       = r_addr;
    assign Sel        = r_sel;
    assign SendData   = r_wdata;
    assign Strb       = r_strb;

endmodule

// File: doc/apb_requester_arbiter.md
Name: apb_requester_arbiter

Overview:
- Shares one APB requester between `Masters` local clients using round-robin arbitration.
- Sequences the requester's Start/RD/WR command interface and holds the command fields stable for the whole transfer.
- Detects completion from the requester's Busy falling edge, then returns read data and a per-master Done pulse.
- Sits between on-chip clients (DMA, CPU bridge, config engine) and the APB requester.

Parameters:
- DataWidth, 32, APB data width; StrbWidth = DataWidth/8.
- AddrWidth, 32, APB address width.
- Slaves, 4, number of APB completers; DecoSlaves = (Slaves>1) ? $clog2(Slaves) : 1.
- Masters, 3, number of requesting clients (>=2); IdxW = $clog2(Masters).
- TimeoutCycles, 256, max Busy-high cycles per transfer before flagging; counter width $clog2(TimeoutCycles+1).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- Req  in  Masters  per-master level request; held until that master's Done.
- ReqWrite  in  Masters  1=write, 0=read.
- ReqAddr  in  Masters*AddrWidth  flattened; master m at [m*AddrWidth +: AddrWidth].
- ReqSel  in  Masters*DecoSlaves  flattened completer select.
- ReqData  in  Masters*DataWidth  flattened write data.
- ReqStrb  in  Masters*StrbWidth  flattened write strobes.
- Grant  out  Masters  one-hot; high for the owning master from ISSUE through XFER.
- Done  out  Masters  one-cycle completion pulse for the owner.
- RespData  out  DataWidth  read data; valid while Done is high for a read, then held.
- TimeoutErr  out  1  sticky flag, cleared only by reset.
- Start, RD, WR  out  1 each  requester command strobes.
- Addr  out  AddrWidth  requester address.
- Sel  out  DecoSlaves  requester completer select.
- SendData  out  DataWidth  requester write data.
- Strb  out  StrbWidth  requester write strobes.
- Busy  in  1  requester busy.
- DataReceived  in  DataWidth  requester read data.

Behaviour:
- Reset (async, PRESETn=0):
  - State=IDLE; all outputs 0; timeout counter 0.
  - RR pointer = Masters-1, so master 0 has highest priority first.
  - Reset mid-transfer abandons the transfer silently: no Done pulse.
- FSM states: IDLE, ISSUE, XFER.
- IDLE:
  - If any Req bit is set, winner = first set bit searching upward from pointer+1, wrapping modulo Masters.
  - At the clock edge: latch winner index, register its Addr/Sel/SendData/Strb/ReqWrite, set Grant, update pointer to winner, go to ISSUE.
  - If no Req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Start=1; WR=latched write; RD=!latched write.
  - Go to XFER unconditionally.
- XFER:
  - Start=RD=WR=0; Addr/Sel/SendData/Strb held unchanged (the requester re-samples them in its setup/access phases).
  - While Busy=1: increment timeout counter. When it reaches TimeoutCycles, set TimeoutErr (sticky); the transfer is not aborted.
  - First cycle after ISSUE with Busy=0: the transfer is complete. Registered at the edge:
    - Done[owner]=1.
    - RespData=DataReceived if read; RespData unchanged if write.
    - Grant=0, counter=0, state goes to IDLE.
- Done lasts exactly 1 cycle.
- IDLE arbitrates in the same cycle Done is high, so back-to-back grants are possible.
- Command fields are frozen at grant. Changes on Req* after grant are ignored.
- If the owner drops Req mid-transfer, the transfer still completes and Done still pulses.
- Simultaneous requests: strict rotation. With all requesting and pointer=0, the grant order is 1,2,0,1,...
- A single continuous requester is re-granted every transfer.
- Latency with a zero-wait completer, Req first seen high in cycle 0:
  - Cycle 1: ISSUE, Start=1.
  - Cycle 2: requester setup, Busy=1.
  - Cycle 3: access, PREADY=1.
  - Cycle 4: Busy=0 observed.
  - Cycle 5: Done high.
- Each completer wait state adds 1 cycle.

Test Plan:
- Read, master 0: Req=001, ReqAddr0=0x40, ReqSel0=2; PREADY=1 with PRDATA=0xDEADBEEF -> Start high only in cycle 1 with RD=1; PSELx=0100; Done=001 in cycle 5; RespData=0xDEADBEEF.
- Write, master 2: ReqData2=0x12345678, ReqStrb2=0xF -> WR=1 at Start; PWDATA=0x12345678; Done=100 in cycle 5; RespData unchanged.
- Round-robin: Req=111 held, 6 transfers -> Grant sequence 001,010,100,001,010,100; back-to-back ISSUE 1 cycle after each Done.
- Wait states with TimeoutCycles=4, PREADY low for 6 access cycles -> TimeoutErr=1 and stays 1; transfer still completes with Done; a following normal transfer leaves TimeoutErr=1.
- Reset mid-XFER: PRESETn low for 1 cycle while Busy=1 -> Grant/Done/Start/Addr = 0 immediately, no Done; after release, Req=011 grants master 0 first.
- Req drop: master 1 drops Req in cycle 2 -> Done=010 still pulses; Addr stays stable through completion.
